// File: rtl/rv_pkg.sv
// Shared types for the rv_g_core fetch stage: instruction length, fetch FSM
// states and the queue entry carried from fetch to decode.
package rv_pkg;

  localparam int ILEN     = 32;
  localparam int PC_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_e;

  // The PC field is sized for the widest supported address; narrower cores zero-extend.
  typedef struct packed {
    logic [ILEN-1:0]     instr;
    logic [PC_MAX_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Circular instruction queue: up to two pushes and one pop per cycle,
// synchronous flush, and a free-slot count for the fetch request logic.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   flush_i,
  input  logic                   push0_i,
  input  fetch_entry_t           push0_entry_i,
  input  logic                   push1_i,
  input  fetch_entry_t           push1_entry_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] free_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // push1 is only meaningful together with push0, so it lands in the slot after it
      if (push0_i) begin
        mem_d[wr_ptr_q] = push0_entry_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (push0_i && push1_i) begin
        mem_d[wr_ptr_q + PTR_W'(1)] = push1_entry_i;
        wr_ptr_d                    = wr_ptr_q + PTR_W'(2);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push0_i) + CNT_W'(push0_i & push1_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign free_o  = CNT_W'(DEPTH) - count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (srst_i)
    !(push0_i && (count_q == CNT_W'(DEPTH))) &&
    !(push0_i && push1_i && (count_q >= CNT_W'(DEPTH - 1))));

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem request FSM, splits
// 64-bit fetch words into 32-bit instructions and queues them for decode.
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 64,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_data_i,
  input  logic                      imem_ack_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                      instr_valid_o,
  output logic [ILEN-1:0]           instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                      instr_ready_i
);

  localparam int AW    = MEM_ADDR_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             req_q, req_d;

  logic [AW-1:0]    pc_base, pc_next_word, pc_plus4, redir_pc, boot_pc;
  logic [CNT_W-1:0] free_slots, free_after, push_cnt;
  logic             ack_fetch, push0, push1, pop, head_valid;
  fetch_entry_t     entry0, entry1, head;
  logic             unused_bits;

  assign pc_base      = {pc_q[AW-1:3], 3'b000};
  assign pc_next_word = pc_base + AW'(8);
  assign pc_plus4     = pc_q + AW'(4);
  assign redir_pc     = {redirect_addr_i[AW-1:2], 2'b00};
  assign boot_pc      = {boot_addr_i[AW-1:2], 2'b00};
  assign pop          = head_valid & instr_ready_i & ~redirect_i;
  assign ack_fetch    = (state_q == REQ) && imem_ack_i && !redirect_i;
  assign unused_bits  = ^{redirect_addr_i[1:0], boot_addr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    push0    = 1'b0;
    push1    = 1'b0;
    push_cnt = '0;
    entry0   = '0;
    entry1   = '0;

    // A fetch starting at an odd instruction slot only yields the upper half
    if (ack_fetch) begin
      push0 = 1'b1;
      if (pc_q[2]) begin
        entry0.instr = imem_data_i[2*ILEN-1:ILEN];
        entry0.pc    = PC_MAX_W'(pc_q);
        push_cnt     = CNT_W'(1);
      end else begin
        entry0.instr = imem_data_i[ILEN-1:0];
        entry0.pc    = PC_MAX_W'(pc_q);
        push1        = 1'b1;
        entry1.instr = imem_data_i[2*ILEN-1:ILEN];
        entry1.pc    = PC_MAX_W'(pc_plus4);
        push_cnt     = CNT_W'(2);
      end
    end
    free_after = free_slots + CNT_W'(pop) - push_cnt;

    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          pc_d = redir_pc;
        end else if (free_slots >= CNT_W'(2)) begin
          state_d = REQ;
          addr_d  = pc_base;
        end
      end
      REQ: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = imem_ack_i ? IDLE : DROP;
        end else if (imem_ack_i) begin
          pc_d = pc_next_word;
          if (free_after >= CNT_W'(2)) begin
            state_d = REQ;
            addr_d  = pc_next_word;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        // The stale address stays on the bus until its ack retires it
        if (redirect_i) begin
          pc_d = redir_pc;
        end
        if (imem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pc_q    <= boot_pc;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  rv_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .flush_i       (redirect_i),
    .push0_i       (push0),
    .push0_entry_i (entry0),
    .push1_i       (push1),
    .push1_entry_i (entry1),
    .pop_i         (pop),
    .valid_o       (head_valid),
    .head_o        (head),
    .free_o        (free_slots)
  );

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = head_valid;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc[AW-1:0];

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit with a latency-configurable imem responder
// whose data encodes the fetch address, so misplaced or stale words are visible.
module tb_rv_fetch_unit;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          srst;
  logic [AW-1:0] boot_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [63:0]   imem_data;
  logic          imem_ack;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  int tests    = 0;
  int failures = 0;
  int lat      = 1;
  int wait_cnt = 0;
  bit ack_en   = 1'b1;
  logic [AW-1:0] acks[$];
  logic [AW-1:0] pops[$];

  always #5 clk = ~clk;

  rv_fetch_unit #(
    .MEM_ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(64),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .boot_addr_i    (boot_addr),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_data_i    (imem_data),
    .imem_ack_i     (imem_ack),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .instr_valid_o  (instr_valid),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .instr_ready_i  (instr_ready)
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F ^ {a[47:32], 16'h0000};
  endfunction

  // One clock cycle: respond to imem, log pops, advance to the next negedge.
  task automatic step();
    logic do_ack;
    do_ack    = imem_req && ack_en && (wait_cnt >= lat);
    imem_ack  = do_ack;
    imem_data = do_ack ? {word_of(imem_addr + 64'd4), word_of(imem_addr)} : 64'hDEAD_BEEF_DEAD_BEEF;
    if (do_ack) acks.push_back(imem_addr);
    if (instr_valid && instr_ready && !redirect && !srst) begin
      pops.push_back(instr_pc);
      tests++;
      if (instr !== word_of(instr_pc)) begin
        failures++;
        $display("FAIL instr_data pc=%h got=%h exp=%h", instr_pc, instr, word_of(instr_pc));
      end
    end
    wait_cnt = (imem_req && !do_ack) ? wait_cnt + 1 : 0;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [AW-1:0] boot);
    srst        = 1'b1;
    boot_addr   = boot;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    ack_en      = 1'b1;
    lat         = 1;
    step();
    step();
    srst     = 1'b0;
    wait_cnt = 0;
    acks.delete();
    pops.delete();
  endtask

  task automatic check_seq(input string name, input logic [AW-1:0] base, input int min_n);
    int bad;
    bad = 0;
    foreach (pops[i]) if (pops[i] !== base + 64'(4 * i)) bad++;
    tests++;
    if (bad != 0 || pops.size() < min_n) begin
      failures++;
      $display("FAIL %s pops=%0d bad=%0d first=%h exp_base=%h min=%0d", name, pops.size(), bad,
               (pops.size() > 0) ? pops[0] : 64'hX, base, min_n);
    end
  endtask

  task automatic test_reset();
    do_reset(64'h8000_0000);
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl req=%b valid=%b exp 0 0", imem_req, instr_valid);
    end
    tests++;
    if (imem_addr !== 64'h0 || instr !== 32'h0 || instr_pc !== 64'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h instr=%h pc=%h exp 0", imem_addr, instr, instr_pc);
    end
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0000) begin
      failures++;
      $display("FAIL first_req req=%b addr=%h exp 1 80000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset(64'h8000_0000);
    run(24);
    tests++;
    if (acks.size() < 4 || acks[0] !== 64'h8000_0000 || acks[1] !== 64'h8000_0008 ||
        acks[2] !== 64'h8000_0010 || acks[3] !== 64'h8000_0018) begin
      failures++;
      $display("FAIL seq_addrs n=%0d a0=%h a1=%h exp 80000000 80000008", acks.size(),
               (acks.size() > 0) ? acks[0] : 64'hX, (acks.size() > 1) ? acks[1] : 64'hX);
    end
    check_seq("seq_pcs", 64'h8000_0000, 12);
  endtask

  task automatic test_boot_unaligned();
    do_reset(64'h1004);
    run(12);
    tests++;
    if (acks.size() < 2 || acks[0] !== 64'h1000 || acks[1] !== 64'h1008) begin
      failures++;
      $display("FAIL boot_addrs n=%0d a0=%h a1=%h exp 1000 1008", acks.size(),
               (acks.size() > 0) ? acks[0] : 64'hX, (acks.size() > 1) ? acks[1] : 64'hX);
    end
    check_seq("boot_pcs", 64'h1004, 4);
  endtask

  task automatic test_backpressure();
    do_reset(64'h8000_0000);
    instr_ready = 1'b0;
    run(20);
    tests++;
    if (acks.size() != 2) begin
      failures++;
      $display("FAIL bp_acks got=%0d exp=2", acks.size());
    end
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 64'h8000_0000) begin
      failures++;
      $display("FAIL bp_hold req=%b valid=%b pc=%h exp 0 1 80000000", imem_req, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    run(30);
    check_seq("bp_resume", 64'h8000_0000, 12);
  endtask

  task automatic test_back_to_back();
    do_reset(64'h8000_0000);
    lat = 0;
    run(40);
    check_seq("b2b_rate", 64'h8000_0000, 36);
  endtask

  task automatic test_redirect_outstanding();
    do_reset(64'h8000_0000);
    ack_en = 1'b0;
    step();
    tests++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL ro_pre req=%b exp 1", imem_req);
    end
    redirect      = 1'b1;
    redirect_addr = 64'h2000;
    step();
    redirect = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0000 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ro_drop req=%b addr=%h valid=%b exp 1 80000000 0", imem_req, imem_addr, instr_valid);
    end
    step();
    step();
    acks.delete();
    ack_en = 1'b1;
    lat    = 0;
    step();
    lat = 1;
    tests++;
    if (acks.size() != 1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ro_stale acks=%0d req=%b valid=%b exp 1 0 0", acks.size(), imem_req, instr_valid);
    end
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
      failures++;
      $display("FAIL ro_newreq req=%b addr=%h exp 1 2000", imem_req, imem_addr);
    end
    run(12);
    check_seq("ro_pcs", 64'h2000, 4);
  endtask

  task automatic test_redirect_ack_pop();
    int n;
    do_reset(64'h8000_0000);
    n = 0;
    while (!(imem_req && (wait_cnt >= lat) && instr_valid) && n < 30) begin
      step();
      n++;
    end
    tests++;
    if (n >= 30) begin
      failures++;
      $display("FAIL rap_setup timeout cycles=%0d exp <30", n);
    end
    redirect      = 1'b1;
    redirect_addr = 64'h2000;
    step();
    redirect = 1'b0;
    pops.delete();
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rap_flush valid=%b req=%b exp 0 0", instr_valid, imem_req);
    end
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h2000 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rap_newreq req=%b addr=%h valid=%b exp 1 2000 0", imem_req, imem_addr, instr_valid);
    end
    run(12);
    check_seq("rap_pcs", 64'h2000, 4);
  endtask

  task automatic test_redirect_unaligned();
    do_reset(64'h8000_0000);
    redirect      = 1'b1;
    redirect_addr = 64'h3006;
    step();
    redirect = 1'b0;
    tests++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL ru_idle req=%b exp 0", imem_req);
    end
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h3000) begin
      failures++;
      $display("FAIL ru_req req=%b addr=%h exp 1 3000", imem_req, imem_addr);
    end
    run(12);
    check_seq("ru_pcs", 64'h3004, 4);
  endtask

  task automatic test_wrap();
    do_reset(64'hFFFF_FFFF_FFFF_FFF8);
    run(12);
    tests++;
    if (acks.size() < 2 || acks[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || acks[1] !== 64'h0) begin
      failures++;
      $display("FAIL wrap_addrs n=%0d a0=%h a1=%h exp fffffffffffffff8 0", acks.size(),
               (acks.size() > 0) ? acks[0] : 64'hX, (acks.size() > 1) ? acks[1] : 64'hX);
    end
    check_seq("wrap_pcs", 64'hFFFF_FFFF_FFFF_FFF8, 4);
  endtask

  initial begin
    srst          = 1'b1;
    boot_addr     = '0;
    imem_data     = '0;
    imem_ack      = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    instr_ready   = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_boot_unaligned();
    test_backpressure();
    test_back_to_back();
    test_redirect_outstanding();
    test_redirect_ack_pop();
    test_redirect_unaligned();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
